// File: rtl/seq_vedic_mul16.sv
// 16x16 unsigned multiplier: one shared 8x8 Vedic unit and one 16-bit adder slice, four partial products.
// Latency 5 cycles from accepted start to done; start is ignored while busy (no queueing).
module seq_vedic_mul16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [2:0] {S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] product_q, product_d;
  logic        done_q, done_d;

  logic [7:0]  mul_x, mul_y;
  logic [15:0] pp;
  logic [15:0] add_x;
  logic [16:0] add_sum;
  logic        slice_cout;
  logic [7:0]  inc_out;

  // Urdhva Tiryagbhyam: column k sums every crosswise bit pair x[i]&y[k-i] plus the carry from column k-1.
  function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    logic [4:0]  col;
    logic [3:0]  carry;
    p     = '0;
    carry = '0;
    for (int k = 0; k < 15; k++) begin
      col = {1'b0, carry};
      for (int i = 0; i < 8; i++) begin
        if ((k - i) >= 0 && (k - i) < 8) begin
          col = col + {4'b0000, x[i] & y[3'(k - i)]};
        end
      end
      p[k]  = col[0];
      carry = col[4:1];
    end
    p[15] = carry[0];
    return p;
  endfunction

  always_comb begin
    mul_x = a_q[7:0];
    mul_y = b_q[7:0];
    case (state_q)
      S_PP1:   begin mul_x = a_q[15:8]; mul_y = b_q[7:0];  end
      S_PP2:   begin mul_x = a_q[7:0];  mul_y = b_q[15:8]; end
      S_PP3:   begin mul_x = a_q[15:8]; mul_y = b_q[15:8]; end
      default: begin mul_x = a_q[7:0];  mul_y = b_q[7:0];  end
    endcase
    pp = vedic8(mul_x, mul_y);

    // The final partial product lands two bytes up; the cross terms land one byte up.
    add_x      = (state_q == S_PP3) ? acc_q[31:16] : acc_q[23:8];
    add_sum    = {1'b0, add_x} + {1'b0, pp};
    slice_cout = add_sum[16];
    inc_out    = acc_q[31:24] + {7'b0000000, slice_cout};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_PP0;
        end
      end
      S_PP0: begin
        acc_d   = {16'h0000, pp};
        state_d = S_PP1;
      end
      // acc[31:24] is zero entering PP1, so the incrementer simply deposits the carry in bit 24.
      S_PP1: begin
        acc_d   = {inc_out, add_sum[15:0], acc_q[7:0]};
        state_d = S_PP2;
      end
      S_PP2: begin
        acc_d   = {inc_out, add_sum[15:0], acc_q[7:0]};
        state_d = S_PP3;
      end
      S_PP3: begin
        product_d = {add_sum[15:0], acc_q[15:0]};
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_vedic_mul16.sv
// Scoreboard bench for seq_vedic_mul16: a cycle-level acceptance model queues a*b with its due cycle,
// a negedge monitor checks busy/done/product every cycle and pops results on done.
module tb_seq_vedic_mul16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  seq_vedic_mul16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          m = 0;          // remaining busy cycles after the current edge
  int          rst_cnt = 0;
  logic [15:0] cur_a = '0;
  logic [15:0] cur_b = '0;

  int          total = 0;
  int          bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Acceptance model: a request is taken whenever the unit is idle; the result is due 5 edges later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m = 0;
        rst_cnt++;
      end else if (m == 0 && start) begin
        exp_q.push_back('{prod: 32'(a) * 32'(b), due: cyc + 5});
        cur_a = a;
        cur_b = b;
        m = 4;
      end else if (m > 0) begin
        m--;
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  initial begin
    int          seen_rst;
    logic [31:0] exp_prod;
    logic        pp3_flag;
    logic        exp_done;
    exp_t        e;
    seen_rst = 0;
    exp_prod = '0;
    pp3_flag = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        exp_q.delete();
        exp_prod = '0;
        pp3_flag = 1'b0;
      end
      if (m == 1 && dut.slice_cout) pp3_flag = 1'b1;

      chk("busy", {31'b0, busy}, {31'b0, (m != 0)});
      exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("done", {31'b0, done}, {31'b0, exp_done});
      if (done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("pp3_carry_out", {31'b0, pp3_flag}, 32'h0);
        pp3_flag = 1'b0;
        exp_prod = e.prod;
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        void'(exp_q.pop_front());
      end
      chk("product", product, exp_prod);

      if (cur_a == 16'hFFFF && cur_b == 16'hFFFF) begin
        if (m == 3) chk("acc_after_pp0", dut.acc_q, 32'h0000FE01);
        if (m == 2) chk("acc_after_pp1", dut.acc_q, 32'h00FEFF01);
        if (m == 1) chk("acc_after_pp2", dut.acc_q, 32'h01FD0001);
      end
    end
  end

  // Called at a negedge; waits for idle so the start is taken on the very next edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
    while (m != 0) @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h5678);
    issue(16'hFFFF, 16'hFFFF);
    issue(16'h00FF, 16'hFF00);
    issue(16'h0000, 16'h1234);

    // start held high with operands scrambled every cycle
    while (m != 0) @(negedge clk);
    start = 1'b1;
    a     = 16'd3;
    b     = 16'd5;
    repeat (12) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    start = 1'b0;

    // abort a multiply with reset during PP2
    while (m != 0) @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'hFFFF, 16'h0002);

    repeat (1000) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(16'($urandom), 16'($urandom));
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
